fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller. Issues one instruction-bus request at a time
// for the current PC, buffers the returned word and presents it to the decoder
// until it is consumed. Later stages may redirect the PC at any time; a redirect
// always wins over stall and over sequential PC advance. A response that arrives
// for a request made obsolete by a redirect is dropped (DISCARD state).
// Misaligned PCs (pc[1:0] != 0) never reach the bus: they are presented directly
// as a flagged, zero instruction so the pipeline can raise the trap.
//
// Ports
//   clk              in   1   sole clock, rising edge
//   reset            in   1   synchronous, active-high reset
//   ireq_valid       out  1   instruction-bus request valid
//   ireq_addr        out  64  instruction-bus request address
//   iresp_data_ok    in   1   bus response valid, completes the outstanding request
//   iresp_data       in   32  fetched instruction word
//   redirect_valid   in   1   PC redirect from later stages
//   redirect_pc      in   64  redirect target
//   stall            in   1   decoder cannot accept the presented instruction
//   instr_valid      out  1   presented instruction valid
//   instr            out  32  presented instruction word (0 when misaligned)
//   instr_pc         out  64  PC of the presented instruction
//   instr_misaligned out  1   presented PC is misaligned, no bus access was made
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic        instr_misaligned
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   // Architectural state
   state_t      state_r;
   logic [63:0] pc_r;
   logic [63:0] pend_pc_r;
   logic [31:0] buf_r;
   logic [63:0] buf_pc_r;
   logic        buf_mis_r;

   // Registered handshake outputs
   logic        ireq_valid_r;
   logic        instr_valid_r;

   // Next-state values
   state_t      state_s;
   logic [63:0] pc_s;
   logic [63:0] pend_pc_s;
   logic [31:0] buf_s;
   logic [63:0] buf_pc_s;
   logic        buf_mis_s;
   logic        pc_aligned_s;

   // Sequential successor of a PC; plain 64-bit add, wraps modulo 2^64.
   function automatic logic [63:0] next_seq_pc(input logic [63:0] cur_pc);
      return cur_pc + 64'd4;
   endfunction

   // A PC is fetchable over the bus only when word aligned.
   function automatic logic is_aligned(input logic [63:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

   // The bus request is decoded from the state being entered, so it is
   // registered and visible in the very cycle the state is entered.
   function automatic logic req_for(input state_t st, input logic [63:0] addr);
      return ((st == FETCH) && is_aligned(addr)) || (st == DISCARD);
   endfunction

   assign pc_aligned_s = is_aligned(pc_r);

   // Next-state logic: redirect first, then response/stall handling per state.
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      pend_pc_s = pend_pc_r;
      buf_s     = buf_r;
      buf_pc_s  = buf_pc_r;
      buf_mis_s = buf_mis_r;

      case (state_r)
         FETCH: begin
            if (redirect_valid) begin
               if (pc_aligned_s && !iresp_data_ok) begin
                  // Request still in flight: its response must be swallowed
                  // before the new target can be requested.
                  pend_pc_s = redirect_pc;
                  state_s   = DISCARD;
               end else begin
                  // No request, or it completes now and is simply dropped.
                  pc_s    = redirect_pc;
                  state_s = FETCH;
               end
            end else if (!pc_aligned_s) begin
               buf_s     = 32'd0;
               buf_pc_s  = pc_r;
               buf_mis_s = 1'b1;
               state_s   = HOLD;
            end else if (iresp_data_ok) begin
               buf_s     = iresp_data;
               buf_pc_s  = pc_r;
               buf_mis_s = 1'b0;
               state_s   = HOLD;
            end else begin
               state_s = FETCH;
            end
         end

         DISCARD: begin
            if (iresp_data_ok) begin
               // A redirect arriving with the final response is newer than
               // anything already parked in pend_pc.
               pc_s    = redirect_valid ? redirect_pc : pend_pc_r;
               state_s = FETCH;
            end else if (redirect_valid) begin
               pend_pc_s = redirect_pc;
               state_s   = DISCARD;
            end else begin
               state_s = DISCARD;
            end
         end

         HOLD: begin
            if (redirect_valid) begin
               pc_s    = redirect_pc;
               state_s = FETCH;
            end else if (!stall) begin
               pc_s    = next_seq_pc(buf_pc_r);
               state_s = FETCH;
            end else begin
               state_s = HOLD;
            end
         end

         default: begin
            // Unreachable encoding: restart fetching at the current PC.
            pc_s    = pc_r;
            state_s = FETCH;
         end
      endcase
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= FETCH;
         pc_r          <= PCINIT;
         pend_pc_r     <= 64'd0;
         buf_r         <= 32'd0;
         buf_pc_r      <= 64'd0;
         buf_mis_r     <= 1'b0;
         ireq_valid_r  <= req_for(FETCH, PCINIT);
         instr_valid_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         pend_pc_r     <= pend_pc_s;
         buf_r         <= buf_s;
         buf_pc_r      <= buf_pc_s;
         buf_mis_r     <= buf_mis_s;
         ireq_valid_r  <= req_for(state_s, pc_s);
         instr_valid_r <= (state_s == HOLD);
      end
   end

   // pc only changes when no request is outstanding, so driving the address
   // straight from it keeps ireq_addr stable for the life of a request.
   assign ireq_valid       = ireq_valid_r;
   assign ireq_addr        = pc_r;
   assign instr_valid      = instr_valid_r;
   assign instr            = buf_r;
   assign instr_pc         = buf_pc_r;
   assign instr_misaligned = buf_mis_r;

endmodule
